// File: rtl/branch_predictor_pkg.sv
// Shared encodings and sizing for the branch predictor slice.
package branch_predictor_pkg;

  // Width of the per-entry direction counter
  localparam int BP_cnt_len = 2;

  // Default number of direct-mapped table entries
  localparam int BP_DEFAULT_ENTRIES = 16;

  // Direction counter states; prediction is taken when the MSB is set
  typedef enum logic [BP_cnt_len-1:0] {
    BP_SN = 2'b00,
    BP_WN = 2'b01,
    BP_WT = 2'b10,
    BP_ST = 2'b11
  } bp_cnt_e;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_cnt_e cnt,
  input  logic    taken,
  output bp_cnt_e cnt_next
);

  // Step toward ST on taken, toward SN on not-taken, holding at either end
  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != BP_ST) cnt_next = bp_cnt_e'(cnt + 2'd1);
    end else begin
      if (cnt != BP_SN) cnt_next = bp_cnt_e'(cnt - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// mispredict redirect generation and resolved-branch statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BP_ENTRIES = BP_DEFAULT_ENTRIES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX   = $clog2(BP_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  // Counters saturate rather than wrap so long runs never read back as small
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic             valid_q  [BP_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BP_ENTRIES];
  logic [31:0]      target_q [BP_ENTRIES];
  bp_cnt_e          cnt_q    [BP_ENTRIES];

  logic [IDX-1:0]   rd_idx;
  logic             rd_hit;
  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  bp_cnt_e          up_cnt_next;
  logic             mispredict_p0;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = &{1'b0, if_pc[1:0]};

  // Fetch-side lookup; reads the registered table so writes are not bypassed
  always_comb begin
    rd_idx      = if_pc[IDX+1:2];
    rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == if_pc[31:IDX+2]);
    pred_taken  = rd_hit && cnt_q[rd_idx][1];
    pred_target = pred_taken ? target_q[rd_idx] : 32'd0;
  end

  // Resolve-side lookup and mispredict detection
  always_comb begin
    up_idx        = upd_pc[IDX+1:2];
    up_tag        = upd_pc[31:IDX+2];
    up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    mispredict_p0 = upd_valid &&
                    ((upd_taken != upd_pred_taken) ||
                     (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
  end

  bp_sat_counter u_sat_counter (
    .cnt      (cnt_q[up_idx]),
    .taken    (upd_taken),
    .cnt_next (up_cnt_next)
  );

  // Table update: train on hit, allocate on taken miss, ignore not-taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        cnt_q[i]    <= BP_SN;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        cnt_q[up_idx] <= up_cnt_next;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        cnt_q[up_idx]    <= BP_WT;
      end
    end
  end

  // ---- stage p1: registered redirect pulse, restart PC skips the delay slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= mispredict_p0;
      if (mispredict_p0) redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd8;
    end
  end

  // Saturating resolved-branch and mispredict counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (upd_valid)     stat_branches    <= sat_inc(stat_branches);
      if (mispredict_p0) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor with a table-level reference model.
module tb_branch_predictor;

  localparam int ENT  = 16;
  localparam int IDXB = $clog2(ENT);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'd0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'd0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predictor #(.BP_ENTRIES(ENT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one record per table slot, counter as an integer 0..3
  typedef struct {
    bit        v;
    bit [31:0] tag;
    bit [31:0] tgt;
    int        cnt;
  } ment_t;

  ment_t     mtab [ENT];
  bit [31:0] m_nbr = 0;
  bit [31:0] m_nmp = 0;
  bit [31:0] m_rpc = 0;

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      mtab[i].v = 0; mtab[i].tag = 0; mtab[i].tgt = 0; mtab[i].cnt = 0;
    end
    m_nbr = 0; m_nmp = 0; m_rpc = 0;
  endfunction

  function automatic void mpred(input bit [31:0] pc, output bit t, output bit [31:0] tg);
    int i = int'((pc >> 2) % ENT);
    t  = mtab[i].v && (mtab[i].tag == (pc >> (2 + IDXB))) && (mtab[i].cnt >= 2);
    tg = t ? mtab[i].tgt : 32'd0;
  endfunction

  function automatic void mupdate(input bit [31:0] pc, input bit t, input bit [31:0] tg);
    int i = int'((pc >> 2) % ENT);
    bit hit = mtab[i].v && (mtab[i].tag == (pc >> (2 + IDXB)));
    if (hit) begin
      mtab[i].cnt = t ? ((mtab[i].cnt == 3) ? 3 : mtab[i].cnt + 1)
                      : ((mtab[i].cnt == 0) ? 0 : mtab[i].cnt - 1);
      if (t) mtab[i].tgt = tg;
    end else if (t) begin
      mtab[i].v = 1; mtab[i].tag = pc >> (2 + IDXB); mtab[i].tgt = tg; mtab[i].cnt = 2;
    end
  endfunction

  typedef struct { int cyc; bit t; bit [31:0] tg; } pexp_t;
  typedef struct { int cyc; bit rv; bit [31:0] rpc; bit [31:0] nb; bit [31:0] nm; } oexp_t;

  pexp_t qp[$];
  oexp_t qo[$];

  // Monitor: compare combinational prediction and post-edge outputs
  pexp_t pe;
  oexp_t oe;
  always @(negedge clk) begin
    if (rst_n) begin
      while (qp.size() > 0 && qp[0].cyc <= cyc) begin
        pe = qp.pop_front();
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, pe.t});
        chk("pred_target", pred_target, pe.tg);
      end
      while (qo.size() > 0 && qo[0].cyc <= cyc) begin
        oe = qo.pop_front();
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, oe.rv});
        chk("redirect_pc", redirect_pc, oe.rpc);
        chk("stat_branches", stat_branches, oe.nb);
        chk("stat_mispredicts", stat_mispredicts, oe.nm);
      end
    end
  end

  // Driver: called at posedge+1, returns at the next posedge+1
  task automatic step(input bit uv, input bit [31:0] upc, input bit ut, input bit [31:0] utg,
                      input bit upt, input bit [31:0] uptg, input bit [31:0] ipc);
    bit        et, mp, rv;
    bit [31:0] etg;
    pexp_t     p;
    oexp_t     o;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    upd_pred_taken = upt; upd_pred_target = uptg; if_pc = ipc;
    mpred(ipc, et, etg);
    p.cyc = cyc; p.t = et; p.tg = etg;
    qp.push_back(p);
    mp = uv && ((ut != upt) || (ut && upt && (utg != uptg)));
    rv = mp;
    if (uv && m_nbr != 32'hFFFF_FFFF) m_nbr = m_nbr + 1;
    if (mp && m_nmp != 32'hFFFF_FFFF) m_nmp = m_nmp + 1;
    if (mp) m_rpc = ut ? utg : upc + 32'd8;
    o.cyc = cyc + 1; o.rv = rv; o.rpc = m_rpc; o.nb = m_nbr; o.nm = m_nmp;
    qo.push_back(o);
    if (uv) mupdate(upc, ut, utg);
    @(posedge clk); #1;
  endtask

  // Same as step, but the carried prediction is what the predictor said
  task automatic stepm(input bit uv, input bit [31:0] upc, input bit ut, input bit [31:0] utg,
                       input bit [31:0] ipc);
    bit        pt;
    bit [31:0] ptg;
    mpred(upc, pt, ptg);
    step(uv, upc, ut, utg, pt, ptg, ipc);
  endtask

  function automatic bit [31:0] pick_pc();
    bit [31:0] bases [3];
    bases[0] = 32'h0040_0000; bases[1] = 32'h0040_0040; bases[2] = 32'h1000_0000;
    return bases[$urandom_range(0, 2)] + (32'($urandom_range(0, 15)) << 2);
  endfunction

  localparam bit [31:0] PA = 32'h0040_0010;
  localparam bit [31:0] PT = 32'h0040_0100;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] tgts [4];
    bit [31:0] upc, utg, uptg, ipc;
    bit        uv, ut, upt;
    tgts[0] = 32'h0040_0100; tgts[1] = 32'h0040_0200;
    tgts[2] = 32'h0040_0300; tgts[3] = 32'h0080_0000;
    model_reset();

    // Reset state with a lookup PC applied
    if_pc = PA;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_stat_branches", stat_branches, 32'd0);
    chk("rst_stat_mispredicts", stat_mispredicts, 32'd0);
    rst_n = 1'b1;

    // Allocation, training, target mismatch, aliasing
    step(1, PA, 1, PT, 0, 0, PA);
    step(0, 0, 0, 0, 0, 0, PA);
    repeat (4) stepm(1, PA, 0, 0, PA);
    step(1, PA, 1, PT, 0, 0, PA);
    step(1, PA, 1, PT, 0, 0, PA);
    step(1, PA, 1, PT, 1, 32'h0040_0200, PA);
    step(1, 32'h0040_0050, 1, 32'h0040_0300, 0, 0, PA);
    step(0, 0, 0, 0, 0, 0, PA);
    step(0, 0, 0, 0, 0, 0, 32'h0040_0050);
    // Back-to-back mispredicts with distinct restart PCs
    step(1, 32'h0040_0080, 1, 32'h0040_0200, 0, 0, 32'h0040_0080);
    step(1, 32'h0040_0090, 0, 0, 1, 32'h0040_0300, 32'h0040_0080);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      upc = pick_pc();
      ut  = 1'($urandom_range(0, 1));
      utg = tgts[$urandom_range(0, 3)];
      mpred(upc, upt, uptg);
      if ($urandom_range(0, 9) < 3) begin
        upt  = 1'($urandom_range(0, 1));
        uptg = upt ? tgts[$urandom_range(0, 3)] : 32'd0;
      end
      uv  = ($urandom_range(0, 3) != 0);
      ipc = ($urandom_range(0, 2) == 0) ? upc : pick_pc();
      step(uv, upc, ut, utg, upt, uptg, ipc);
    end

    // Reset asserted during a mispredicting update
    stepm(1, PA, 1, PT, PA);
    upd_valid = 1; upd_pc = PA; upd_taken = 1; upd_target = 32'h0040_0400;
    upd_pred_taken = 0; upd_pred_target = 0; if_pc = PA;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("mid_rst_pred_target", pred_target, 32'd0);
    chk("mid_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("mid_rst_redirect_pc", redirect_pc, 32'd0);
    chk("mid_rst_stat_branches", stat_branches, 32'd0);
    chk("mid_rst_stat_mispredicts", stat_mispredicts, 32'd0);
    @(posedge clk); #1;
    upd_valid = 0;
    rst_n = 1'b1;
    qp.delete(); qo.delete();
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("post_rst_stat_branches", stat_branches, 32'd0);
    step(0, 0, 0, 0, 0, 0, PA);
    step(1, PA, 0, 0, 0, 0, PA);

    @(negedge clk); #1;
    chk("pred_queue_drained", 32'(qp.size()), 32'd0);
    chk("out_queue_drained", 32'(qo.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
